// File: rtl/output_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit output bus: one-hot registered grant held until release.
// Optional grant revocation after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module output_bus_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IW       = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [8*N-1:0]    data_in,
    output logic [N-1:0]      gnt,
    output logic [7:0]        bus_out,
    output logic              bus_busy,
    output logic [IW-1:0]     owner,
    output logic              timeout
);

    localparam int unsigned HW = 8;
    localparam logic [HW-1:0] HOLD_SAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_t;

    // Elaboration-time parameter sanity checks
    if (N < 2 || N > 8) begin : g_bad_n
        $error("output_bus_arbiter: N must be 2..8");
    end
    if (IW != $clog2(N)) begin : g_bad_iw
        $error("output_bus_arbiter: IW must equal clog2(N)");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("output_bus_arbiter: MAX_HOLD must be 2..255");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_d;
    logic [N-1:0]    gnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   win;
    logic            win_vld;
    logic [IW-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
    logic            timeout_q, timeout_d;
    logic            hold_expired;

    assign hold_expired = (hold_q == HW'(MAX_HOLD));
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

    // Round-robin search starting just after the most recent owner
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_q) + k) % N);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: state_d = win_vld ? BUSY : IDLE;
`ifdef ARB_TIMEOUT_EN
            BUSY: state_d = (req[owner] && !hold_expired) ? BUSY : IDLE;
`else
            BUSY: state_d = req[owner] ? BUSY : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = '0;
        owner_d = owner;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
`ifdef ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = N'(1) << win;
                    owner_d = win;
                    hold_d  = HW'(1);
                end
            end
            BUSY: begin
                // Release takes precedence over a simultaneous timeout
                if (!req[owner]) begin
                    ptr_d = owner;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_expired) begin
                    ptr_d     = owner;
                    timeout_d = 1'b1;
`endif
                end else begin
                    gnt_d  = N'(1) << owner;
                    hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= '0;
            owner  <= '0;
            ptr_q  <= IW'(N - 1);
            hold_q <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            gnt    <= gnt_d;
            owner  <= owner_d;
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus_busy = |gnt;

    // Grant is one-hot, so at most one byte lane reaches the bus
    always_comb begin
        bus_out = 8'h00;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                bus_out = data_in[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_output_bus_arbiter.sv
// Scoreboard bench for output_bus_arbiter: a behavioural reference model predicts each cycle's outputs,
// a monitor on the falling edge compares them. Define ARB_TIMEOUT_EN to match a timeout-enabled build.
module tb_output_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned MH = 4;
    localparam int NI = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   data_in;
    logic [N-1:0]     gnt;
    logic [7:0]       bus_out;
    logic             bus_busy;
    logic [IW-1:0]    owner;
    logic             timeout;

    always #5 clk = ~clk;

    output_bus_arbiter #(.N(N), .IW(IW), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .bus_out  (bus_out),
        .bus_busy (bus_busy),
        .owner    (owner),
        .timeout  (timeout)
    );

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [IW-1:0] owner;
        logic [7:0]    bus;
        logic          busy;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: who holds the bus, who held it last, how long this tenure has run
    bit   m_busy;
    int   m_owner;
    int   m_last;
    int   m_tenure;
    bit   m_to;

    bit             cur_rst;
    logic [N-1:0]   cur_req;
    logic [8*N-1:0] cur_data;

    // Requester agents
    bit  want [NI];
    int  served [NI];
    int  target [NI];
    int  fixed_target;
    int  raise_pct;
    bit  allow_abandon;

    function automatic void model_step(bit r, logic [N-1:0] rq);
        if (r) begin
            m_busy = 0; m_owner = 0; m_last = NI - 1; m_tenure = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                for (int k = 1; k <= NI; k++) begin
                    int i;
                    i = (m_last + k) % NI;
                    if (!m_busy && rq[i]) begin
                        m_busy = 1; m_owner = i; m_tenure = 1;
                    end
                end
            end else if (!rq[m_owner]) begin
                m_busy = 0; m_last = m_owner;
`ifdef ARB_TIMEOUT_EN
            end else if (m_tenure == int'(MH)) begin
                m_busy = 0; m_last = m_owner; m_to = 1;
`endif
            end else begin
                m_tenure = (m_tenure >= 255) ? 255 : m_tenure + 1;
            end
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.gnt = '0;
        e.bus = 8'h00;
        if (m_busy) begin
            e.gnt[m_owner] = 1'b1;
            e.bus = cur_data[m_owner*8 +: 8];
        end
        e.owner = IW'(m_owner);
        e.busy  = m_busy;
        e.to    = m_to;
        return e;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
        model_step(cur_rst, cur_req);
    endtask

    task automatic apply(input bit r, input logic [N-1:0] rq);
        cur_rst = r;
        cur_req = rq;
        for (int i = 0; i < NI; i++) cur_data[8*i +: 8] = 8'($urandom);
        rst     = cur_rst;
        req     = cur_req;
        data_in = cur_data;
        exp_q.push_back(expect_now());
    endtask

    task automatic step(input bit r, input logic [N-1:0] rq);
        advance();
        apply(r, rq);
    endtask

    function automatic logic [N-1:0] want_vec();
        logic [N-1:0] v;
        for (int i = 0; i < NI; i++) v[i] = want[i];
        return v;
    endfunction

    // Each agent holds req until served for its target, may give up while waiting, and re-requests randomly
    task automatic agents_update();
        for (int i = 0; i < NI; i++) begin
            if (want[i]) begin
                if (m_busy && m_owner == i) begin
                    served[i]++;
                    if (served[i] >= target[i]) want[i] = 0;
                end else if (allow_abandon && served[i] == 0 && $urandom_range(0, 15) == 0) begin
                    want[i] = 0;
                end
            end else if (raise_pct > 0 && $urandom_range(0, 99) < raise_pct) begin
                want[i]   = 1;
                served[i] = 0;
                if (fixed_target > 0) target[i] = fixed_target;
                else if ($urandom_range(0, 4) == 0) target[i] = 12;
                else target[i] = $urandom_range(1, 6);
            end
        end
    endtask

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    // Monitor: pops one expectation per cycle and compares away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk("gnt",      32'(gnt),      32'(e.gnt));
            chk("owner",    32'(owner),    32'(e.owner));
            chk("bus_out",  32'(bus_out),  32'(e.bus));
            chk("bus_busy", 32'(bus_busy), 32'(e.busy));
            chk("timeout",  32'(timeout),  32'(e.to));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_busy = 0; m_owner = 0; m_last = NI - 1; m_tenure = 0; m_to = 0;
        cur_rst = 1; cur_req = 4'b1111; cur_data = 32'($urandom);
        rst = cur_rst; req = cur_req; data_in = cur_data;
        fixed_target = 0; raise_pct = 0; allow_abandon = 0;
        for (int i = 0; i < NI; i++) begin want[i] = 0; served[i] = 0; target[i] = 1; end

        // Reset held two edges with all requesting, then round-robin with 3-cycle tenures
        step(1, 4'b1111);
        step(0, 4'b1111);
        for (int i = 0; i < NI; i++) begin want[i] = 1; served[i] = 0; target[i] = 3; end
        fixed_target = 3;
        repeat (20) begin
            advance();
            agents_update();
            apply(0, want_vec());
        end

        // Single requester, then release
        repeat (4) step(0, 4'b0100);
        repeat (2) step(0, 4'b0000);

        // Fairness after owner 1 releases
        repeat (3) step(0, 4'b0010);
        step(0, 4'b0000);
        repeat (4) step(0, 4'b0011);
        repeat (4) step(0, 4'b0011);
        repeat (2) step(0, 4'b0000);

        // Long hold (revoked only when timeout is built in), then a competitor
        repeat (12) step(0, 4'b0001);
        repeat (8) step(0, 4'b0011);
        repeat (2) step(0, 4'b0000);

        // Reset in the middle of a tenure
        repeat (3) step(0, 4'b1000);
        step(1, 4'b1000);
        step(0, 4'b0000);
        repeat (3) step(0, 4'b1000);
        repeat (2) step(0, 4'b0000);

        // Randomized traffic with abandoned requests and occasional resets
        for (int i = 0; i < NI; i++) begin want[i] = cur_req[i]; served[i] = 0; end
        fixed_target = 0; raise_pct = 30; allow_abandon = 1;
        repeat (3000) begin
            advance();
            agents_update();
            apply(($urandom_range(0, 99) == 0), want_vec());
        end

        advance();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
